// File: rtl/calc_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer driving an external 4-bit adder_subtractor.
// Mul is shift-add, div is restoring; results reported over a start/busy/done handshake.
module calc_sequencer #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   opa,
  input  logic [W-1:0]   opb,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           carry,
  output logic           overflow,
  output logic           div_err,
  output logic [W-1:0]   as_a,
  output logic [W-1:0]   as_b,
  output logic           as_mode,
  input  logic [W-1:0]   as_sum,
  input  logic           as_cout,
  input  logic           as_overflow
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;

  state_t        state;
  logic          sub_r;
  logic [W-1:0]  acc;
  logic [W-1:0]  q;
  logic [W-1:0]  m;
  logic          c;
  logic [CW-1:0] cnt;

  logic [W-1:0]  div_s;
  logic [W-1:0]  r_nxt;
  logic [W-1:0]  q_nxt;
  logic [2*W:0]  mul_shift;
  logic          last;

  always_comb begin
    as_a    = '0;
    as_b    = '0;
    as_mode = 1'b0;
    div_s   = {acc[W-2:0], q[W-1]};
    case (state)
      ADDSUB: begin
        as_a    = m;
        as_b    = q;
        as_mode = sub_r;
      end
      MUL: begin
        as_a = acc;
        as_b = m;
      end
      DIV: begin
        as_a    = div_s;
        as_b    = m;
        as_mode = 1'b1;
      end
      default: ;
    endcase

    mul_shift = q[0] ? ({as_cout, as_sum, q} >> 1) : ({c, acc, q} >> 1);

    if (acc[W-1] | as_cout) begin
      r_nxt = as_sum;
      q_nxt = {q[W-2:0], 1'b1};
    end else begin
      r_nxt = div_s;
      q_nxt = {q[W-2:0], 1'b0};
    end

    last = (cnt == CW'(W-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sub_r    <= 1'b0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sub_r    <= op[0];
            acc      <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            div_err  <= 1'b0;
            busy     <= 1'b1;
            if (op == 2'b11) begin
              m <= opb;
              q <= opa;
              if (opb == '0) begin
                div_err <= 1'b1;
                result  <= '0;
                state   <= DONE;
              end else begin
                state <= DIV;
              end
            end else begin
              m     <= opa;
              q     <= opb;
              state <= op[1] ? MUL : ADDSUB;
            end
          end
        end
        ADDSUB: begin
          result   <= {{W{1'b0}}, as_sum};
          carry    <= as_cout;
          overflow <= as_overflow;
          done     <= 1'b1;
          state    <= DONE;
        end
        MUL: begin
          {c, acc, q} <= mul_shift;
          cnt         <= cnt + CW'(1);
          if (last) begin
            result <= mul_shift[2*W-1:0];
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DIV: begin
          acc <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            result <= {r_nxt, q_nxt};
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Divide-by-zero enters DONE with done low, so it holds one extra
          // cycle to pulse done at the same edge as an add/sub would.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural adder_subtractor and a
// scoreboard of expected results checked when done pulses.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [3:0] opa, opb;
  logic       busy, done, carry, overflow, div_err;
  logic [7:0] result;
  logic [3:0] as_a, as_b, as_sum;
  logic       as_mode, as_cout, as_overflow;

  logic [3:0] bb;
  logic [4:0] as_full;

  always #5 clk = ~clk;

  assign bb          = as_mode ? ~as_b : as_b;
  assign as_full     = {1'b0, as_a} + {1'b0, bb} + {4'b0, as_mode};
  assign as_sum      = as_full[3:0];
  assign as_cout     = as_full[4];
  assign as_overflow = (as_a[3] == bb[3]) && (as_sum[3] != as_a[3]);

  calc_sequencer #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .div_err(div_err),
    .as_a(as_a), .as_b(as_b), .as_mode(as_mode),
    .as_sum(as_sum), .as_cout(as_cout), .as_overflow(as_overflow)
  );

  typedef struct {
    logic [7:0]  res;
    logic        c;
    logic        ov;
    logic        de;
    int unsigned lat;
  } exp_t;

  exp_t scb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   sa, sbv, s;
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sbv = b[3] ? int'(b) - 16 : int'(b);
    e.res = 8'h00; e.c = 1'b0; e.ov = 1'b0; e.de = 1'b0; e.lat = 1;
    case (o)
      2'b00: begin
        e.res = 8'((int'(a) + int'(b)) % 16);
        e.c   = (int'(a) + int'(b)) > 15;
        s     = sa + sbv;
        e.ov  = (s > 7) || (s < -8);
      end
      2'b01: begin
        e.res = 8'((int'(a) - int'(b) + 16) % 16);
        e.c   = (a >= b);
        s     = sa - sbv;
        e.ov  = (s > 7) || (s < -8);
      end
      2'b10: begin
        e.res = 8'(int'(a) * int'(b));
        e.lat = 4;
      end
      default: begin
        if (b == 4'h0) begin
          e.de = 1'b1;
        end else begin
          e.res = {4'(int'(a) % int'(b)), 4'(int'(a) / int'(b))};
          e.lat = 4;
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the first idle negedge after done.
  task automatic run_op(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b, input bit noise);
    exp_t e, got;
    bit   seen;
    e = model(o, a, b);
    scb.push_back(e);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!noise) start = 1'b0;
    seen = 1'b0;
    for (int unsigned n = 1; n <= 12 && !seen; n++) begin
      if (done) begin
        seen = 1'b1;
        got  = scb.pop_front();
        chk("done_cycle", n, got.lat + 1);
        chk("result", result, got.res);
        chk("carry", carry, got.c);
        chk("overflow", overflow, got.ov);
        chk("div_err", div_err, got.de);
        chk("busy_at_done", busy, 1);
      end else begin
        chk("busy_wait", busy, 1);
      end
      if (noise) begin
        start = 1'b1;
        op    = 2'($urandom);
        opa   = 4'($urandom);
        opb   = 4'($urandom);
      end
      if (!seen) @(negedge clk);
    end
    chk("done_timeout", seen, 1);
    if (!seen) void'(scb.pop_front());
    @(negedge clk);
    start = 1'b0;
    chk("busy_after", busy, 0);
    chk("done_pulse_end", done, 0);
    chk("result_hold", result, e.res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; opa = 4'h0; opb = 4'h0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, overflow, div_err}, 0);
    chk("rst_as_port", {as_a, as_b, as_mode}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 4'h7, 4'h5, 1'b0);  // 0C, ov=1
    run_op(2'b01, 4'h3, 4'h5, 1'b0);  // 0E
    run_op(2'b01, 4'h5, 4'h3, 1'b0);  // 02, carry=1
    run_op(2'b11, 4'h9, 4'h0, 1'b0);  // div by zero, carry cleared
    run_op(2'b10, 4'hF, 4'hF, 1'b1);  // E1 with start noise through MUL and DONE
    run_op(2'b10, 4'h6, 4'h0, 1'b0);  // 00
    run_op(2'b11, 4'hD, 4'h4, 1'b0);  // 13
    run_op(2'b11, 4'hF, 4'h1, 1'b1);  // 0F with start noise
    for (int i = 0; i < 6; i++)
      run_op(2'($urandom), 4'($urandom), 4'($urandom), i[0]);

    // Asynchronous reset during the second divide iteration
    op = 2'b11; opa = 4'hD; opb = 4'h4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {carry, overflow, div_err}, 0);
    chk("midrst_as_port", {as_a, as_b, as_mode}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    run_op(2'b11, 4'hD, 4'h4, 1'b0);
    run_op(2'b00, 4'h9, 4'h9, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
